// File: rtl/xbar_age_to_banks_rr.sv
// AGE-group <-> SpM bank-group crossbar with per-bank round-robin arbitration and read-data return.
// Build option XBAR_A2B_OUTREG_EN registers the bank-side outputs and adds one cycle of read latency.
module xbar_age_to_banks_rr #(
  parameter int N_AGE    = 4,
  parameter int N_BANKS  = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int BANK_LAT = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_AGE-1:0]          age_req_i,
  input  logic [N_AGE-1:0]          age_we_i,
  input  logic [N_AGE*N_BANKS-1:0]  age_bank_i,
  input  logic [N_AGE*ADDR_W-1:0]   age_addr_i,
  input  logic [N_AGE*DATA_W-1:0]   age_wdata_i,
  output logic [N_AGE-1:0]          age_gnt_o,
  output logic [N_AGE-1:0]          age_rvalid_o,
  output logic [N_AGE*DATA_W-1:0]   age_rdata_o,
  output logic [N_BANKS-1:0]        bank_req_o,
  output logic [N_BANKS-1:0]        bank_we_n_o,
  output logic [N_BANKS*ADDR_W-1:0] bank_addr_o,
  output logic [N_BANKS*DATA_W-1:0] bank_wdata_o,
  input  logic [N_BANKS*DATA_W-1:0] bank_rdata_i,
  output logic [15:0]               conflict_cnt_o,
  output logic                      sel_err_o
);
  localparam int PTR_W  = $clog2(N_AGE);
  localparam int BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
`ifdef XBAR_A2B_OUTREG_EN
  localparam int DEPTH = BANK_LAT + 1;
`else
  localparam int DEPTH = BANK_LAT;
`endif

  function automatic logic is_onehot(input logic [N_BANKS-1:0] v);
    return (v != '0) && ((v & (v - N_BANKS'(1))) == '0);
  endfunction

  function automatic logic [BANK_W-1:0] low_idx(input logic [N_BANKS-1:0] v);
    logic [BANK_W-1:0] r;
    r = '0;
    for (int b = N_BANKS-1; b >= 0; b--) if (v[b]) r = BANK_W'(b);
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int k);
    return PTR_W'((int'(ptr) + k) % N_AGE);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
    return (int'(w) == N_AGE-1) ? '0 : w + PTR_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [N_AGE-1:0]   onehot, hot_any, gnt_c;
  logic [BANK_W-1:0]  eff_bank [N_AGE];
  logic [N_AGE-1:0]   cand     [N_BANKS];
  logic [PTR_W-1:0]   rr_ptr   [N_BANKS];
  logic [PTR_W-1:0]   winner   [N_BANKS];
  logic [N_BANKS-1:0] bank_gnt;
  logic               denied, bad_sel;

  logic [N_BANKS-1:0]        req_c, we_n_c;
  logic [N_BANKS*ADDR_W-1:0] addr_c;
  logic [N_BANKS*DATA_W-1:0] wdata_c;

  logic             ret_vld_p [N_BANKS][DEPTH];
  logic [PTR_W-1:0] ret_idx_p [N_BANKS][DEPTH];

  always_comb begin
    for (int i = 0; i < N_AGE; i++) begin
      hot_any[i]  = |age_bank_i[i*N_BANKS +: N_BANKS];
      onehot[i]   = is_onehot(age_bank_i[i*N_BANKS +: N_BANKS]);
      eff_bank[i] = low_idx(age_bank_i[i*N_BANKS +: N_BANKS]);
    end
    for (int b = 0; b < N_BANKS; b++)
      for (int i = 0; i < N_AGE; i++)
        cand[b][i] = ~rst_i & age_req_i[i] & hot_any[i] & (int'(eff_bank[i]) == b);
  end

  // Scan downwards from the pointer so the candidate closest to rr_ptr is assigned last.
  always_comb begin
    bank_gnt = '0;
    gnt_c    = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      winner[b] = '0;
      for (int k = N_AGE-1; k >= 0; k--) begin
        if (cand[b][rr_idx(rr_ptr[b], k)]) begin
          bank_gnt[b] = 1'b1;
          winner[b]   = rr_idx(rr_ptr[b], k);
        end
      end
      if (bank_gnt[b]) gnt_c[winner[b]] = 1'b1;
    end
  end

  assign age_gnt_o = gnt_c;
  assign denied    = |(age_req_i & onehot & ~gnt_c);
  assign bad_sel   = |(age_req_i & ~onehot);

  always_comb begin
    req_c   = bank_gnt;
    we_n_c  = '1;
    addr_c  = '0;
    wdata_c = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_gnt[b]) begin
        we_n_c[b]                   = ~age_we_i[winner[b]];
        addr_c[b*ADDR_W +: ADDR_W]  = age_addr_i[int'(winner[b])*ADDR_W +: ADDR_W];
        wdata_c[b*DATA_W +: DATA_W] = age_wdata_i[int'(winner[b])*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < N_BANKS; b++) rr_ptr[b] <= '0;
      conflict_cnt_o <= '0;
      sel_err_o      <= 1'b0;
    end else begin
      for (int b = 0; b < N_BANKS; b++)
        if (bank_gnt[b]) rr_ptr[b] <= next_ptr(winner[b]);
      if (denied)  conflict_cnt_o <= sat_inc(conflict_cnt_o);
      if (bad_sel) sel_err_o      <= 1'b1;
    end
  end

`ifdef XBAR_A2B_OUTREG_EN
  // Bank-side register stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_req_o   <= '0;
      bank_we_n_o  <= '1;
      bank_addr_o  <= '0;
      bank_wdata_o <= '0;
    end else begin
      bank_req_o   <= req_c;
      bank_we_n_o  <= we_n_c;
      bank_addr_o  <= addr_c;
      bank_wdata_o <= wdata_c;
    end
  end
`else
  assign bank_req_o   = req_c;
  assign bank_we_n_o  = we_n_c;
  assign bank_addr_o  = addr_c;
  assign bank_wdata_o = wdata_c;
`endif

  // Read-return shift registers: valid is reset, the AGE index rides along unreset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < N_BANKS; b++)
        for (int d = 0; d < DEPTH; d++) ret_vld_p[b][d] <= 1'b0;
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        ret_vld_p[b][0] <= bank_gnt[b] & ~age_we_i[winner[b]];
        for (int d = 1; d < DEPTH; d++) ret_vld_p[b][d] <= ret_vld_p[b][d-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < N_BANKS; b++) begin
      ret_idx_p[b][0] <= winner[b];
      for (int d = 1; d < DEPTH; d++) ret_idx_p[b][d] <= ret_idx_p[b][d-1];
    end
  end

  always_comb begin
    age_rvalid_o = '0;
    age_rdata_o  = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (ret_vld_p[b][DEPTH-1] && !rst_i) begin
        age_rvalid_o[ret_idx_p[b][DEPTH-1]] = 1'b1;
        age_rdata_o[int'(ret_idx_p[b][DEPTH-1])*DATA_W +: DATA_W] = bank_rdata_i[b*DATA_W +: DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_xbar_age_to_banks_rr.sv
// Table-driven bench for xbar_age_to_banks_rr with a read-return scoreboard.
module tb_xbar_age_to_banks_rr;
`ifdef XBAR_A2B_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_i;
  logic [3:0]   age_req_i, age_we_i;
  logic [31:0]  age_bank_i;
  logic [127:0] age_addr_i, age_wdata_i;
  logic [3:0]   age_gnt_o, age_rvalid_o;
  logic [127:0] age_rdata_o;
  logic [7:0]   bank_req_o, bank_we_n_o;
  logic [255:0] bank_addr_o, bank_wdata_o, bank_rdata_i;
  logic [15:0]  conflict_cnt_o;
  logic         sel_err_o;

  xbar_age_to_banks_rr dut (
    .clk_i(clk), .rst_i(rst_i),
    .age_req_i(age_req_i), .age_we_i(age_we_i), .age_bank_i(age_bank_i),
    .age_addr_i(age_addr_i), .age_wdata_i(age_wdata_i),
    .age_gnt_o(age_gnt_o), .age_rvalid_o(age_rvalid_o), .age_rdata_o(age_rdata_o),
    .bank_req_o(bank_req_o), .bank_we_n_o(bank_we_n_o), .bank_addr_o(bank_addr_o),
    .bank_wdata_o(bank_wdata_o), .bank_rdata_i(bank_rdata_i),
    .conflict_cnt_o(conflict_cnt_o), .sel_err_o(sel_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req, we;
    logic [31:0] bank, abase;
    logic [3:0]  gnt;
    logic [7:0]  breq, bwen;
    logic [15:0] cnt;
    logic        err;
  } vec_t;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] data;
  } ret_t;

  int     n_test = 0, n_fail = 0, cyc = 0;
  ret_t   sb[$], keep[$];
  vec_t   tbl[$];
  logic [3:0]   ev;
  logic [127:0] ed;
  logic         pend = 1'b0;
  logic [7:0]   p_req, p_wen;
  logic [255:0] p_addr, p_wdata;

  function automatic vec_t mk(input logic [3:0] req, we, input logic [31:0] bank, abase,
                              input logic [3:0] gnt, input logic [7:0] breq, bwen,
                              input logic [15:0] cnt, input logic err);
    vec_t v;
    v.req = req; v.we = we; v.bank = bank; v.abase = abase; v.gnt = gnt;
    v.breq = breq; v.bwen = bwen; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] bank_data(input int b);
    return (b == 3) ? 32'hCAFE : 32'hB000 + 32'(b);
  endfunction

  function automatic int low_bit(input logic [7:0] v);
    int r;
    r = 0;
    for (int b = 7; b >= 0; b--) if (v[b]) r = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_test++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bank(input logic [7:0] req, wen, input logic [255:0] addr, wdata);
    chk("bank_req", 256'(bank_req_o), 256'(req));
    chk("bank_we_n", 256'(bank_we_n_o), 256'(wen));
    chk("bank_addr", bank_addr_o, addr);
    chk("bank_wdata", bank_wdata_o, wdata);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Read-return scoreboard
  always @(negedge clk) begin
    ev = '0;
    ed = '0;
    keep = {};
    foreach (sb[k]) begin
      if (sb[k].due <= cyc) begin
        ev[sb[k].idx] = 1'b1;
        ed[sb[k].idx*32 +: 32] = sb[k].data;
      end else keep.push_back(sb[k]);
    end
    sb = keep;
    if (ev != '0 || age_rvalid_o != '0) begin
      chk($sformatf("rvalid@%0d", cyc), 256'(age_rvalid_o), 256'(ev));
      chk($sformatf("rdata@%0d", cyc), 256'(age_rdata_o), 256'(ed));
    end
  end

  task automatic step(input int id, input vec_t v, input bit push_en);
    logic [255:0] ea, ew;
    int b;
    @(posedge clk); #1;
`ifdef XBAR_A2B_OUTREG_EN
    if (pend) chk_bank(p_req, p_wen, p_addr, p_wdata);
    pend = 1'b0;
`endif
    age_req_i  = v.req;
    age_we_i   = v.we;
    age_bank_i = v.bank;
    for (int i = 0; i < 4; i++) age_addr_i[i*32 +: 32] = v.abase + 32'(i);
    ea = '0;
    ew = '0;
    for (int i = 0; i < 4; i++) begin
      if (v.gnt[i]) begin
        b = low_bit(v.bank[i*8 +: 8]);
        ea[b*32 +: 32] = v.abase + 32'(i);
        ew[b*32 +: 32] = 32'hA0 + 32'(i);
        if (push_en && !v.we[i]) sb.push_back('{due: cyc + LAT, idx: i, data: bank_data(b)});
      end
    end
    @(negedge clk);
    chk($sformatf("gnt v%0d", id), 256'(age_gnt_o), 256'(v.gnt));
    chk($sformatf("cnt v%0d", id), 256'(conflict_cnt_o), 256'(v.cnt));
    chk($sformatf("sel_err v%0d", id), 256'(sel_err_o), 256'(v.err));
`ifdef XBAR_A2B_OUTREG_EN
    pend = 1'b1; p_req = v.breq; p_wen = v.bwen; p_addr = ea; p_wdata = ew;
`else
    chk_bank(v.breq, v.bwen, ea, ew);
`endif
  endtask

  initial begin
    rst_i = 1'b1;
    age_req_i = '0; age_we_i = '0; age_bank_i = '0; age_addr_i = '0;
    for (int i = 0; i < 4; i++) age_wdata_i[i*32 +: 32] = 32'hA0 + 32'(i);
    for (int b = 0; b < 8; b++) bank_rdata_i[b*32 +: 32] = bank_data(b);

    // single read, full conflict, disjoint writes, pointer wrap, select error
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h00000008, 32'h10, 4'b0001, 8'h08, 8'hFF, 16'd0, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0,        32'h0,  4'b0000, 8'h00, 8'hFF, 16'd0, 1'b0));
    tbl.push_back(mk(4'b1111, 4'b0000, 32'h02020202, 32'h20, 4'b0001, 8'h02, 8'hFF, 16'd0, 1'b0));
    tbl.push_back(mk(4'b1110, 4'b0000, 32'h02020202, 32'h20, 4'b0010, 8'h02, 8'hFF, 16'd1, 1'b0));
    tbl.push_back(mk(4'b1100, 4'b0000, 32'h02020202, 32'h20, 4'b0100, 8'h02, 8'hFF, 16'd2, 1'b0));
    tbl.push_back(mk(4'b1000, 4'b0000, 32'h02020202, 32'h20, 4'b1000, 8'h02, 8'hFF, 16'd3, 1'b0));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h02020202, 32'h20, 4'b0001, 8'h02, 8'hFF, 16'd3, 1'b0));
    tbl.push_back(mk(4'b1111, 4'b1111, 32'h40100401, 32'h40, 4'b1111, 8'h55, 8'hAA, 16'd3, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0,        32'h0,  4'b0000, 8'h00, 8'hFF, 16'd3, 1'b0));
    tbl.push_back(mk(4'b0100, 4'b0000, 32'h00200000, 32'h50, 4'b0100, 8'h20, 8'hFF, 16'd3, 1'b0));
    tbl.push_back(mk(4'b1000, 4'b0000, 32'h20000000, 32'h50, 4'b1000, 8'h20, 8'hFF, 16'd3, 1'b0));
    tbl.push_back(mk(4'b1001, 4'b0000, 32'h20000020, 32'h50, 4'b0001, 8'h20, 8'hFF, 16'd3, 1'b0));
    tbl.push_back(mk(4'b1000, 4'b0000, 32'h20000020, 32'h50, 4'b1000, 8'h20, 8'hFF, 16'd4, 1'b0));
    tbl.push_back(mk(4'b0100, 4'b0000, 32'h00000000, 32'h60, 4'b0000, 8'h00, 8'hFF, 16'd4, 1'b0));
    tbl.push_back(mk(4'b0010, 4'b0000, 32'h00003000, 32'h70, 4'b0010, 8'h10, 8'hFF, 16'd4, 1'b1));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0,        32'h0,  4'b0000, 8'h00, 8'hFF, 16'd4, 1'b1));

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset gnt", 256'(age_gnt_o), 256'(0));
    chk("reset rvalid", 256'(age_rvalid_o), 256'(0));
    chk("reset cnt", 256'(conflict_cnt_o), 256'(0));
    chk("reset sel_err", 256'(sel_err_o), 256'(0));
    chk_bank(8'h00, 8'hFF, '0, '0);

    for (int n = 0; n < tbl.size(); n++) step(n, tbl[n], 1'b1);

    // read granted, then reset asserted in the following cycle: the read must never return
    step(100, mk(4'b0001, 4'b0000, 32'h00000004, 32'h200, 4'b0001, 8'h04, 8'hFF, 16'd4, 1'b1), 1'b0);
    @(posedge clk); #1;
    age_req_i = '0; age_bank_i = '0; rst_i = 1'b1; pend = 1'b0;
    @(negedge clk);
    chk("rst rvalid", 256'(age_rvalid_o), 256'(0));
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("post-rst gnt", 256'(age_gnt_o), 256'(0));
    chk("post-rst cnt", 256'(conflict_cnt_o), 256'(0));
    chk("post-rst sel_err", 256'(sel_err_o), 256'(0));
    chk_bank(8'h00, 8'hFF, '0, '0);
    repeat (LAT + 1) begin
      @(negedge clk);
      chk("flushed rvalid", 256'(age_rvalid_o), 256'(0));
    end
    // bank3 pointer was 1 before reset; after reset AGE0 must win over AGE1
    step(101, mk(4'b0011, 4'b0000, 32'h00000808, 32'h300, 4'b0001, 8'h08, 8'hFF, 16'd0, 1'b0), 1'b1);
    step(102, mk(4'b0000, 4'b0000, 32'h0, 32'h0, 4'b0000, 8'h00, 8'hFF, 16'd1, 1'b0), 1'b1);
    repeat (LAT + 2) @(posedge clk);
    #1 chk("scoreboard drained", 256'(sb.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
